// File: rtl/pixel_stream_reader_if.sv
// Pixel beat stream from the image reader to the convolution front end.
interface pixel_stream_reader_if #(
  parameter int unsigned PIX_W = 24,
  parameter int unsigned ROW_W = 5,
  parameter int unsigned COL_W = 5
);
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;
  logic             pix_last;

  modport master (
    output pix_valid, pix_data, pix_row, pix_col, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_row, pix_col, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/pixel_stream_reader.sv
// Sweeps the image buffer read port in raster order and streams one
// {R,G,B} pixel per beat, tagged with row/col and an end-of-frame marker.
module pixel_stream_reader #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PIX_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,      // synchronous, active-high
  input  logic                  start,
  input  logic                  img_ready,
  output logic [ADDR_W-1:0]     raddr,
  input  logic [PIX_W-1:0]      rdata,
  pixel_stream_reader_if.master pix,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned NPIX  = IMG_W * IMG_H;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] raddr_q,     raddr_d;
  logic [ROW_W-1:0]  fetch_row_q, fetch_row_d;
  logic [COL_W-1:0]  fetch_col_q, fetch_col_d;
  logic              pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]  pix_data_q,  pix_data_d;
  logic [ROW_W-1:0]  pix_row_q,   pix_row_d;
  logic [COL_W-1:0]  pix_col_q,   pix_col_d;
  logic              pix_last_q,  pix_last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  logic              accept_c;
  logic              load_c;

  // Handshake: a beat leaves when valid meets ready; refill in the same edge.
  assign accept_c = pix_valid_q && pix.pix_ready;
  assign load_c   = !pix_valid_q || accept_c;

  // Next-state, fetch pointer and output register update.
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    fetch_row_d = fetch_row_q;
    fetch_col_d = fetch_col_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_row_d   = pix_row_q;
    pix_col_d   = pix_col_q;
    pix_last_d  = pix_last_q;

    case (state_q)
      S_IDLE: begin
        raddr_d     = '0;
        fetch_row_d = '0;
        fetch_col_d = '0;
        pix_valid_d = 1'b0;
        if (start && img_ready) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (load_c) begin
          pix_data_d  = rdata;
          pix_row_d   = fetch_row_q;
          pix_col_d   = fetch_col_q;
          pix_last_d  = (raddr_q == LAST_ADDR);
          pix_valid_d = 1'b1;
          if (raddr_q == LAST_ADDR) begin
            // Final pixel captured; pointer parks on the last address.
            state_d = S_DRAIN;
          end else begin
            raddr_d = raddr_q + ADDR_W'(1);
            if (fetch_col_q == LAST_COL) begin
              fetch_col_d = '0;
              fetch_row_d = fetch_row_q + ROW_W'(1);
            end else begin
              fetch_col_d = fetch_col_q + COL_W'(1);
            end
          end
        end
      end

      S_DRAIN: begin
        if (accept_c && pix_last_q) begin
          pix_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        raddr_d     = '0;
        fetch_row_d = '0;
        fetch_col_d = '0;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      raddr_q     <= '0;
      fetch_row_q <= '0;
      fetch_col_q <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_row_q   <= '0;
      pix_col_q   <= '0;
      pix_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      fetch_row_q <= fetch_row_d;
      fetch_col_q <= fetch_col_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_row_q   <= pix_row_d;
      pix_col_q   <= pix_col_d;
      pix_last_q  <= pix_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign raddr         = raddr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_data  = pix_data_q;
  assign pix.pix_row   = pix_row_q;
  assign pix.pix_col   = pix_col_q;
  assign pix.pix_last  = pix_last_q;

endmodule
